// File: rtl/bist_controller.sv
// BIST sequencer for one SRAM macro: steps a deterministic pattern generator, muxes the
// SRAM port between functional and test traffic, and checks read data after READ_LATENCY.
module bist_controller #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic                  pg_rst,
  output logic                  pg_en,
  input  logic [ADDR_WIDTH-1:0] pg_addr,
  input  logic [DATA_WIDTH-1:0] pg_data,
  input  logic [DATA_WIDTH-1:0] pg_check,
  input  logic [MASK_WIDTH-1:0] pg_wmask,
  input  logic                  pg_we,
  input  logic                  pg_re,
  input  logic                  pg_done,
  input  logic                  func_ce,
  input  logic                  func_we,
  input  logic [ADDR_WIDTH-1:0] func_addr,
  input  logic [DATA_WIDTH-1:0] func_din,
  input  logic [MASK_WIDTH-1:0] func_wmask,
  output logic                  func_ready,
  output logic [DATA_WIDTH-1:0] func_dout,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [MASK_WIDTH-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RESET_PG = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0] state, next_state;
  logic [1:0] drain_cnt;

  logic start_go, abort_go, pg_issue, valid_in, mismatch;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [ADDR_WIDTH-1:0]   pipe_addr  [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_check [READ_LATENCY];

  // Abort beats start; start is only honoured from IDLE or DONE.
  assign abort_go = abort && (state != S_IDLE);
  assign start_go = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign pg_issue = (state == S_RUN) && !pg_done;
  assign valid_in = pg_issue && pg_re;

  assign pg_rst     = (state == S_IDLE) || (state == S_RESET_PG);
  assign pg_en      = pg_issue;
  assign func_ready = (state == S_IDLE) || (state == S_DONE);
  assign func_dout  = sram_dout;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start_go) next_state = S_RESET_PG;
      S_RESET_PG: next_state = S_RUN;
      S_RUN:      if (pg_done) next_state = S_DRAIN;
      S_DRAIN:    if (drain_cnt == 2'(READ_LATENCY - 1)) next_state = S_DONE;
      S_DONE:     if (start_go) next_state = S_RESET_PG;
      default:    next_state = S_IDLE;
    endcase
    if (abort_go) next_state = S_IDLE;
  end

  always_comb begin
    // NOTE: every output gets a default first so no branch can leave a latch behind.
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_din   = '0;
    sram_wmask = '0;
    if (func_ready) begin
      sram_ce    = func_ce;
      sram_we    = func_we;
      sram_addr  = func_addr;
      sram_din   = func_din;
      sram_wmask = func_wmask;
    end else if (pg_issue) begin
      sram_ce    = pg_we | pg_re;
      sram_we    = pg_we;
      sram_addr  = pg_addr;
      sram_din   = pg_data;
      sram_wmask = pg_wmask;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      drain_cnt <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      busy      <= (next_state == S_RESET_PG) || (next_state == S_RUN) ||
                   (next_state == S_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pipe_valid <= '0;
    end else if (abort_go || start_go) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= valid_in;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // NOTE: payload stages are not reset; pipe_valid alone qualifies them.
  always_ff @(posedge clk) begin
    pipe_addr[0]  <= pg_addr;
    pipe_check[0] <= pg_check;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_addr[i]  <= pipe_addr[i-1];
      pipe_check[i] <= pipe_check[i-1];
    end
  end

  assign mismatch = pipe_valid[READ_LATENCY-1] &&
                    (sram_dout != pipe_check[READ_LATENCY-1]);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      done            <= 1'b0;
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (start_go) begin
      done            <= 1'b0;
      fail            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (abort_go) begin
      done <= 1'b0;
    end else begin
      if ((state == S_DRAIN) && (next_state == S_DONE)) done <= 1'b1;
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
        if (!fail) begin
          first_fail_addr <= pipe_addr[READ_LATENCY-1];
          first_fail_data <= sram_dout;
        end
      end
    end
  end

endmodule

// File: doc/bist_controller.md
# bist_controller

Built-in self-test sequencer for one SRAM macro. It starts and steps a deterministic pattern generator (any `det_patgen_if` slave, e.g. the enhanced March C- generator), multiplexes the SRAM port between functional traffic and test traffic, compares read data against the generator's expected values after the macro's read latency, and reports pass/fail, failure count and the first failing address and data. It sits between the SRAM macro, the functional access path and the test-mode register interface.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: SRAM address width.
- `DATA_WIDTH`, 32: SRAM data width.
- `MASK_WIDTH`, 4: write-mask width.
- `READ_LATENCY`, 1: cycles from read issue to valid `sram_dout`. Legal range 1..3.
- `CNT_WIDTH`, 16: width of the failure counter.

Ports:
- `clk`  in  1  clock. One clock; all logic is on the rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a test run.
- `abort`  in  1  level; stops the run and returns the block to IDLE.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  sticky; high from run completion until the next `start`.
- `fail`  out  1  sticky; at least one compare mismatch occurred in the last run.
- `fail_count`  out  CNT_WIDTH  number of mismatches, saturating.
- `first_fail_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `first_fail_data`  out  DATA_WIDTH  `sram_dout` at the first mismatch.
- `pg_rst`  out  1  pattern generator reset.
- `pg_en`  out  1  pattern generator enable.
- `pg_addr`  in  ADDR_WIDTH  pattern generator address.
- `pg_data`  in  DATA_WIDTH  pattern generator write data.
- `pg_check`  in  DATA_WIDTH  pattern generator expected read data.
- `pg_wmask`  in  MASK_WIDTH  pattern generator write mask.
- `pg_we`  in  1  pattern generator write enable.
- `pg_re`  in  1  pattern generator read enable.
- `pg_done`  in  1  pattern generator has finished.
- `func_ce`, `func_we`  in  1 each  functional chip enable and write enable.
- `func_addr`, `func_din`, `func_wmask`  in  port widths  functional address, write data and write mask.
- `func_ready`  out  1  functional port owns the SRAM.
- `func_dout`  out  DATA_WIDTH  read data, equal to `sram_dout`.
- `sram_ce`, `sram_we`, `sram_addr`, `sram_din`, `sram_wmask`  out  port widths  macro controls.
- `sram_dout`  in  DATA_WIDTH  macro read data.

## Operation
States:
- IDLE: entered from reset and from `abort`.
  - `start` → RESET_PG.
- RESET_PG: lasts exactly 1 cycle, with `pg_rst`=1 and `pg_en`=0.
  - Clears `done`, `fail`, `fail_count`, `first_fail_*` and the compare pipeline.
  - Always goes to RUN.
- RUN: `pg_en`=1.
  - `sram_ce` = `pg_we | pg_re`.
  - `sram_we` = `pg_we`; `sram_addr`/`sram_din`/`sram_wmask` come from the generator (combinational pass-through).
  - When `pg_done`=1: `pg_en`=0, `sram_ce`=0, next state is DRAIN.
- DRAIN: stays READ_LATENCY cycles with the SRAM idle while in-flight compares retire, then goes to DONE.
- DONE: `done`=1.
  - `start` → RESET_PG.

SRAM ownership:
- SRAM port mux: IDLE and DONE select the `func_*` inputs and set `func_ready`=1.
- Every other state sets `func_ready`=0; `func_*` inputs are ignored, not queued.

Compare pipeline:
- READ_LATENCY-deep shift register of {valid, addr, check}.
- `valid` = `pg_re & sram_ce` in RUN.
- At the output stage, if valid and `sram_dout != check`:
  - `fail` is set.
  - `fail_count` increments, saturating at all-ones.
  - If this is the first mismatch of the run, `first_fail_addr`/`first_fail_data` are captured.
- A mismatch and `start` or `abort` in the same cycle: `start`/`abort` wins.

Boundary behaviour:
- `start` outside IDLE/DONE is ignored.
- `abort` (any state except IDLE) forces IDLE next cycle:
  - pipeline flushed;
  - `pg_en`=0;
  - `done` stays 0;
  - `fail`/count/captures hold.
- `abort` takes priority over `start`.
- `pg_done` asserted in the first RUN cycle is legal and yields zero operations.
- Asynchronous `rstb` assertion mid-run forces IDLE immediately and clears all state.

## Timing
- Reset values:
  - state IDLE;
  - `busy`=0, `done`=0, `fail`=0, `fail_count`=0, `first_fail_addr`=0, `first_fail_data`=0;
  - `pg_rst`=1 (held during reset), `pg_en`=0;
  - `func_ready`=1.
- `busy`=1 in RESET_PG, RUN and DRAIN; registered, asserted the cycle after `start`.
- An operation is issued in every RUN cycle where the generator asserts `we` or `re`. There is no stall; the generator advances each `pg_en` cycle.
- A read issued in cycle N is compared in cycle N+READ_LATENCY. `fail`/`fail_count` update at the edge ending that cycle.
- `done` rises READ_LATENCY+1 cycles after the cycle `pg_done` is first seen in RUN.
- `func_dout` is a combinational copy of `sram_dout`. Functional read latency equals READ_LATENCY.

## Test plan
- Ideal SRAM model (1-cycle read), March generator with MUX_RATIO=4 over 16 words:
  - `start` → `busy` the next cycle;
  - `done`=1, `fail`=0, `fail_count`=0;
  - total RUN cycles = 16 + 4·(4·16) + 16 = 288.
- Stuck-at-1 on bit 3 at address 0x05 → `fail`=1, `first_fail_addr`=0x05, `first_fail_data[3]`=1, `fail_count` equals the number of reads of 0x05 expecting 0.
- READ_LATENCY=3 with a 3-cycle SRAM model → no false fails; `done` 4 cycles after `pg_done`.
- `abort` mid-RUN → IDLE the next cycle, `func_ready`=1, `done`=0. A following `start` gives a clean run with counters cleared.
- Functional writes during RUN are dropped (`sram_we` follows `pg_we`). In DONE, a functional write to 0x0A followed by a read returns the written value.
- `rstb` low during DRAIN → all outputs at reset values immediately. CNT_WIDTH=2 with 5 mismatches → `fail_count`=3.
